// File: rtl/radar_ctrl_pkg.sv
// radar_ctrl_pkg: shared sequencer state encoding and clock-rate constants
package radar_ctrl_pkg;
  localparam int CLK_200M_PER_MS = 200000;
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEBOUNCE_ON = 3'd1,
    ST_PWR_UP      = 3'd2,
    ST_INIT        = 3'd3,
    ST_WAIT_RDY    = 3'd4,
    ST_RUN         = 3'd5,
    ST_PWR_DN      = 3'd6,
    ST_FAULT       = 3'd7
  } state_t;
endpackage

// File: rtl/radar_pwr_seq_ms_tick_gen.sv
// ms_tick_gen: 1 ms tick from clk_200m; in clk_200m rst clr, out tick_1ms high when sub-ms counter is CLK_PER_MS-1
module ms_tick_gen #(
  parameter int CLK_PER_MS = 200000
) (
  input  logic clk_200m,
  input  logic rst,
  input  logic clr,
  output logic tick_1ms
);
  logic [19:0] r_cnt;
  assign tick_1ms = r_cnt == 20'(CLK_PER_MS - 1);
  always_ff @(posedge clk_200m)
    if (rst || clr) r_cnt <= '0;
    else r_cnt <= tick_1ms ? '0 : r_cnt + 20'd1;
endmodule

// File: rtl/radar_pwr_seq.sv
// radar_pwr_seq: front-end power/reset sequencer; in clk_200m rst locked gpio_3 gpio_2, out FPGA_EN FPGA_nRESET init_en ready fault state cnt_ms
module radar_pwr_seq
  import radar_ctrl_pkg::*;
#(
  parameter int CLK_PER_MS  = CLK_200M_PER_MS,
  parameter int DEBOUNCE_MS = 5,
  parameter int PWR_MS      = 50,
  parameter int TIMEOUT_MS  = 6200
) (
  input  logic        clk_200m,
  input  logic        rst,
  input  logic        locked,
  input  logic        gpio_3,
  input  logic        gpio_2,
  output logic        FPGA_EN,
  output logic        FPGA_nRESET,
  output logic        init_en,
  output logic        ready,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] cnt_ms
);
  logic [1:0] r_g3, r_g2;
  logic [15:0] r_cnt_ms;
  logic r_en, r_nrst, r_init, r_ready, r_fault;
  logic w_g3s, w_g2s, w_tick, w_clr, w_done_deb, w_done_pwr, w_done_to;
  logic w_en, w_nrst, w_init, w_ready, w_fault;
  state_t r_state, w_next;
  always_ff @(posedge clk_200m)
    if (rst) begin
      r_g3 <= '0;
      r_g2 <= '0;
    end else begin
      r_g3 <= {r_g3[0], gpio_3};
      r_g2 <= {r_g2[0], gpio_2};
    end
  assign w_g3s = r_g3[1];
  assign w_g2s = r_g2[1];
  assign w_done_deb = w_tick && r_cnt_ms == 16'(DEBOUNCE_MS - 1);
  assign w_done_pwr = w_tick && r_cnt_ms == 16'(PWR_MS - 1);
  assign w_done_to  = w_tick && r_cnt_ms == 16'(TIMEOUT_MS - 1);
  // While the request is still high in RUN/FAULT the release debounce is held at zero
  assign w_clr = (w_next != r_state) || ((r_state == ST_RUN || r_state == ST_FAULT) && w_g3s);
  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk_200m (clk_200m),
    .rst      (rst),
    .clr      (w_clr),
    .tick_1ms (w_tick)
  );
  always_ff @(posedge clk_200m)
    if (rst || w_clr) r_cnt_ms <= '0;
    else if (w_tick && r_cnt_ms != 16'hFFFF) r_cnt_ms <= r_cnt_ms + 16'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:        w_next = (locked && w_g3s) ? ST_DEBOUNCE_ON : ST_IDLE;
      ST_DEBOUNCE_ON: w_next = !w_g3s ? ST_IDLE : w_done_deb ? ST_PWR_UP : ST_DEBOUNCE_ON;
      ST_PWR_UP:      w_next = w_done_pwr ? ST_INIT : ST_PWR_UP;
      ST_INIT:        w_next = ST_WAIT_RDY;
      ST_WAIT_RDY:    w_next = w_g2s ? ST_RUN : w_done_to ? ST_FAULT : ST_WAIT_RDY;
      ST_RUN:         w_next = !w_g2s ? ST_FAULT : (!w_g3s && w_done_deb) ? ST_PWR_DN : ST_RUN;
      ST_PWR_DN:      w_next = w_done_pwr ? ST_IDLE : ST_PWR_DN;
      ST_FAULT:       w_next = (!w_g3s && w_done_deb) ? ST_IDLE : ST_FAULT;
      default:        w_next = ST_IDLE;
    endcase
    if (!locked) w_next = ST_IDLE;
    w_en    = w_next inside {ST_PWR_UP, ST_INIT, ST_WAIT_RDY, ST_RUN, ST_PWR_DN};
    w_nrst  = w_next inside {ST_INIT, ST_WAIT_RDY, ST_RUN};
    w_init  = w_next == ST_INIT;
    w_ready = w_next == ST_RUN;
    w_fault = w_next == ST_FAULT;
  end
  always_ff @(posedge clk_200m)
    if (rst) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_nrst  <= 1'b0;
      r_init  <= 1'b0;
      r_ready <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en    <= w_en;
      r_nrst  <= w_nrst;
      r_init  <= w_init;
      r_ready <= w_ready;
      r_fault <= w_fault;
    end
  assign FPGA_EN     = r_en;
  assign FPGA_nRESET = r_nrst;
  assign init_en     = r_init;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign state       = r_state;
  assign cnt_ms      = r_cnt_ms;
endmodule

// File: tb/tb_radar_pwr_seq.sv
// tb_radar_pwr_seq: directed self-checking bench for radar_pwr_seq with 10-cycle ms
module tb_radar_pwr_seq;
  logic clk_200m = 1'b0, rst = 1'b1, locked = 1'b0, gpio_3 = 1'b0, gpio_2 = 1'b0;
  logic FPGA_EN, FPGA_nRESET, init_en, ready, fault;
  logic [2:0] state;
  logic [15:0] cnt_ms;
  int n_chk = 0, n_pass = 0;
  radar_pwr_seq #(.CLK_PER_MS(10), .DEBOUNCE_MS(2), .PWR_MS(3), .TIMEOUT_MS(20)) dut (
    .clk_200m    (clk_200m),
    .rst         (rst),
    .locked      (locked),
    .gpio_3      (gpio_3),
    .gpio_2      (gpio_2),
    .FPGA_EN     (FPGA_EN),
    .FPGA_nRESET (FPGA_nRESET),
    .init_en     (init_en),
    .ready       (ready),
    .fault       (fault),
    .state       (state),
    .cnt_ms      (cnt_ms)
  );
  always #5 clk_200m = ~clk_200m;
  task automatic step(input int n);
    repeat (n) @(posedge clk_200m);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  initial begin
    step(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_en", 32'(FPGA_EN), 0);
    chk("rst_nrst", 32'(FPGA_nRESET), 0);
    chk("rst_init", 32'(init_en), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cnt", 32'(cnt_ms), 0);
    rst = 1'b0;
    step(1);
    locked = 1'b1;
    gpio_3 = 1'b1;
    step(2);
    chk("up_sync_idle", 32'(state), 0);
    step(1);
    chk("up_deb", 32'(state), 1);
    step(19);
    chk("up_en_pre", 32'(FPGA_EN), 0);
    step(1);
    chk("up_en", 32'(FPGA_EN), 1);
    chk("up_pwr_state", 32'(state), 2);
    chk("up_pwr_nrst", 32'(FPGA_nRESET), 0);
    step(29);
    chk("up_init_pre", 32'(init_en), 0);
    step(1);
    chk("up_init", 32'(init_en), 1);
    chk("up_init_nrst", 32'(FPGA_nRESET), 1);
    chk("up_init_state", 32'(state), 3);
    step(1);
    chk("up_init_post", 32'(init_en), 0);
    chk("up_wait_state", 32'(state), 4);
    step(49);
    gpio_2 = 1'b1;
    step(2);
    chk("up_ready_pre", 32'(ready), 0);
    step(1);
    chk("up_ready", 32'(ready), 1);
    chk("up_run_state", 32'(state), 5);
    chk("run_cnt_held", 32'(cnt_ms), 0);
    gpio_3 = 1'b0;
    step(10);
    gpio_3 = 1'b1;
    step(2);
    chk("pulse_cnt", 32'(cnt_ms), 1);
    step(1);
    chk("pulse_cnt_restart", 32'(cnt_ms), 0);
    step(20);
    chk("pulse_stay_run", 32'(state), 5);
    gpio_3 = 1'b0;
    step(21);
    chk("dn_nrst_pre", 32'(FPGA_nRESET), 1);
    step(1);
    chk("dn_nrst", 32'(FPGA_nRESET), 0);
    chk("dn_en_hold", 32'(FPGA_EN), 1);
    chk("dn_state", 32'(state), 6);
    step(29);
    chk("dn_en_pre", 32'(FPGA_EN), 1);
    step(1);
    chk("dn_en", 32'(FPGA_EN), 0);
    chk("dn_idle", 32'(state), 0);
    gpio_3 = 1'b1;
    step(15);
    chk("gl_deb", 32'(state), 1);
    gpio_3 = 1'b0;
    step(3);
    chk("gl_idle", 32'(state), 0);
    step(30);
    chk("gl_en", 32'(FPGA_EN), 0);
    chk("gl_still_idle", 32'(state), 0);
    gpio_2 = 1'b0;
    gpio_3 = 1'b1;
    step(54);
    chk("to_wait", 32'(state), 4);
    step(199);
    chk("to_fault_pre", 32'(fault), 0);
    step(1);
    chk("to_fault", 32'(fault), 1);
    chk("to_state", 32'(state), 7);
    chk("to_en", 32'(FPGA_EN), 0);
    chk("to_nrst", 32'(FPGA_nRESET), 0);
    gpio_3 = 1'b0;
    step(21);
    chk("to_hold", 32'(state), 7);
    step(1);
    chk("to_idle", 32'(state), 0);
    chk("to_fault_clr", 32'(fault), 0);
    gpio_3 = 1'b1;
    step(54);
    chk("ll_wait", 32'(state), 4);
    step(25);
    chk("ll_cnt", 32'(cnt_ms), 2);
    locked = 1'b0;
    step(1);
    chk("ll_state", 32'(state), 0);
    chk("ll_en", 32'(FPGA_EN), 0);
    chk("ll_nrst", 32'(FPGA_nRESET), 0);
    chk("ll_init", 32'(init_en), 0);
    locked = 1'b1;
    step(1);
    chk("rm_deb", 32'(state), 1);
    step(25);
    chk("rm_pwr", 32'(state), 2);
    chk("rm_en", 32'(FPGA_EN), 1);
    rst = 1'b1;
    step(1);
    chk("rm_state", 32'(state), 0);
    chk("rm_en_clr", 32'(FPGA_EN), 0);
    chk("rm_nrst", 32'(FPGA_nRESET), 0);
    chk("rm_init", 32'(init_en), 0);
    chk("rm_ready", 32'(ready), 0);
    chk("rm_fault", 32'(fault), 0);
    chk("rm_cnt", 32'(cnt_ms), 0);
    rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
